// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: holds one 8-pixel tile row and shifts it out to the LCD.
// It discards the fine-scroll pixels, maps each index through BGP and tracks the LCD X position.
module bg_pixel_fifo #(
  parameter int X_MAX = 160,
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       tclk_in,
  input  logic                       line_start_in,
  input  logic                       window_start_in,
  input  logic [7:0]                 SCX_in,
  input  logic                       valid_pixels_in,
  input  logic [DEPTH-1:0][1:0]      pixels_in,
  output logic                       bg_fifo_empty_out,
  input  logic [7:0]                 BGP_in,
  input  logic                       bg_ena_in,
  output logic                       pixel_valid_out,
  output logic [1:0]                 pixel_index_out,
  output logic [1:0]                 pixel_color_out,
  output logic [$clog2(X_MAX)-1:0]   X_out,
  output logic                       line_done_out,
  output logic                       push_dropped_out
);

  localparam int XW = $clog2(X_MAX);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][1:0] r_fifo;
  logic [CW-1:0]         r_count;
  logic [2:0]            r_discard;
  logic                  r_active;
  logic [XW-1:0]         r_x;
  logic                  r_pix_vld;
  logic [1:0]            r_index;
  logic [1:0]            r_color;
  logic                  r_line_done;
  logic                  r_drop;

  logic                  w_ctl;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_emit;
  logic                  w_last;
  logic [1:0]            w_idx;
  logic [4:0]            w_unused_scx;

  function automatic logic [1:0] pal_map(input logic [7:0] bgp, input logic [1:0] idx);
    case (idx)
      2'd0:    pal_map = bgp[1:0];
      2'd1:    pal_map = bgp[3:2];
      2'd2:    pal_map = bgp[5:4];
      default: pal_map = bgp[7:6];
    endcase
  endfunction

  // Line start and window entry both flush the FIFO and take precedence over push/pop.
  assign w_ctl  = tclk_in & (line_start_in | (window_start_in & r_active));
  assign w_push = tclk_in & ~w_ctl & valid_pixels_in & (r_count == '0);
  assign w_pop  = tclk_in & ~w_ctl & r_active & (r_count != '0);
  assign w_emit = w_pop & (r_discard == 3'd0);
  assign w_last = (r_x == XW'(X_MAX - 1));
  assign w_idx  = bg_ena_in ? r_fifo[0] : 2'd0;
  assign w_unused_scx = SCX_in[7:3];

  // ---- stage p0: control state and registered outputs ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count     <= '0;
      r_discard   <= 3'd0;
      r_active    <= 1'b0;
      r_x         <= '0;
      r_pix_vld   <= 1'b0;
      r_index     <= 2'd0;
      r_color     <= 2'd0;
      r_line_done <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_pix_vld   <= w_emit;
      r_line_done <= w_emit & w_last;
      r_drop      <= tclk_in & valid_pixels_in & (w_ctl | (r_count != '0));
      if (tclk_in && line_start_in) begin
        r_count   <= '0;
        r_x       <= '0;
        r_discard <= SCX_in[2:0];
        r_active  <= 1'b1;
      end else if (w_ctl) begin
        r_count   <= '0;
        r_discard <= 3'd0;
      end else if (w_push) begin
        r_count <= CW'(DEPTH);
      end else if (w_pop) begin
        if (w_emit && w_last) begin
          r_count  <= '0;
          r_active <= 1'b0;
        end else begin
          r_count <= r_count - 1'b1;
        end
        if (r_discard != 3'd0) r_discard <= r_discard - 1'b1;
        if (w_emit && !w_last) r_x <= r_x + 1'b1;
      end
      if (w_emit) begin
        r_index <= w_idx;
        r_color <= pal_map(BGP_in, w_idx);
      end
    end
  end

  // Pixel storage carries no reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk_in) begin
    if (w_push)
      r_fifo <= pixels_in;
    else if (w_pop)
      r_fifo <= {2'b00, r_fifo[DEPTH-1:1]};
  end

  assign bg_fifo_empty_out = (r_count == '0);
  assign pixel_valid_out   = r_pix_vld;
  assign pixel_index_out   = r_index;
  assign pixel_color_out   = r_color;
  assign X_out             = r_x;
  assign line_done_out     = r_line_done;
  assign push_dropped_out  = r_drop;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed-vector bench for bg_pixel_fifo with hand-computed expected values.
module tb_bg_pixel_fifo;

  logic            clk = 1'b0;
  logic            rst, tclk, ls, ws, vld, bge;
  logic [7:0]      scx, bgp;
  logic [7:0][1:0] pix;
  logic            empty, pvld, ldone, pdrop;
  logic [1:0]      pidx, pcol;
  logic [7:0]      xo;

  int n_vec = 0;
  int n_err = 0;

  bg_pixel_fifo #(.X_MAX(160), .DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst), .tclk_in(tclk), .line_start_in(ls),
    .window_start_in(ws), .SCX_in(scx), .valid_pixels_in(vld), .pixels_in(pix),
    .bg_fifo_empty_out(empty), .BGP_in(bgp), .bg_ena_in(bge),
    .pixel_valid_out(pvld), .pixel_index_out(pidx), .pixel_color_out(pcol),
    .X_out(xo), .line_done_out(ldone), .push_dropped_out(pdrop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line_start(input logic [7:0] s);
    scx = s; ls = 1'b1;
    tick();
    ls = 1'b0;
  endtask

  task automatic push(input logic [15:0] p);
    pix = p; vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int strobes, dones, bad;
    rst = 1'b1; tclk = 1'b0; ls = 1'b0; ws = 1'b0; vld = 1'b0;
    bge = 1'b1; scx = 8'h00; bgp = 8'hE4; pix = '0;
    tick(); tick();
    chk("rst_valid", pvld, 0);
    chk("rst_index", pidx, 0);
    chk("rst_color", pcol, 0);
    chk("rst_x", xo, 0);
    chk("rst_done", ldone, 0);
    chk("rst_drop", pdrop, 0);
    chk("rst_empty", empty, 1);
    rst = 1'b0; tclk = 1'b1;

    // basic line: indices 0,1,2,3,0,1,2,3 through BGP=E4
    line_start(8'h00);
    push(16'hE4E4);
    chk("basic_push_novalid", pvld, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("basic_valid", pvld, 1);
      chk("basic_color", pcol, k % 4);
      chk("basic_x", xo, k + 1);
    end
    chk("basic_empty", empty, 1);

    // fine scroll: SCX=5 discards five pixels
    line_start(8'h05);
    push(16'hE4E4);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pvld !== 1'b0 || xo !== 8'd0) bad++;
    end
    chk("scroll_silent", bad, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("scroll_valid", pvld, 1);
      chk("scroll_index", pidx, k);
    end
    chk("scroll_x", xo, 3);

    // rejected push while four entries remain
    line_start(8'h00);
    push(16'hE4E4);
    pops(4);
    chk("rej_x4", xo, 4);
    push(16'hFFFF);
    chk("rej_drop", pdrop, 1);
    chk("rej_pop_index", pidx, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rej_keep_index", pidx, k);
      chk("rej_drop_clear", pdrop, 0);
    end
    chk("rej_empty", empty, 1);
    chk("rej_x", xo, 8);

    // window entry at X=37 with five entries queued
    line_start(8'h06);
    push(16'hE4E4);
    pops(8);
    chk("win_x2", xo, 2);
    for (int g = 0; g < 4; g++) begin
      push(16'hE4E4);
      pops(8);
    end
    push(16'hE4E4);
    pops(3);
    chk("win_pre_x", xo, 37);
    chk("win_pre_empty", empty, 0);
    ws = 1'b1;
    tick();
    ws = 1'b0;
    chk("win_empty", empty, 1);
    chk("win_x", xo, 37);
    chk("win_novalid", pvld, 0);
    push(16'h0006);
    tick();
    chk("win_first_valid", pvld, 1);
    chk("win_first_index", pidx, 2);
    chk("win_first_x", xo, 38);

    // line end: 160 strobes, done on the last
    line_start(8'h00);
    strobes = 0; dones = 0; bad = 0;
    for (int g = 0; g < 20; g++) begin
      push(16'hE4E4);
      for (int k = 0; k < 8; k++) begin
        tick();
        if (pvld) strobes++;
        if (ldone) dones++;
        if (ldone !== ((g == 19) && (k == 7))) bad++;
      end
    end
    chk("end_strobes", strobes, 160);
    chk("end_dones", dones, 1);
    chk("end_done_pos", bad, 0);
    chk("end_x", xo, 159);
    vld = 1'b1; pix = 16'hE4E4;
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (pvld || ldone) strobes++;
    end
    vld = 1'b0;
    chk("end_no_more", strobes, 0);
    chk("end_x_hold", xo, 159);
    chk("end_refilled", empty, 0);

    // tclk gating: nothing moves with tclk low
    line_start(8'h00);
    push(16'hE4E4);
    pops(2);
    chk("gate_pre_index", pidx, 1);
    tclk = 1'b0; vld = 1'b1; ls = 1'b1; ws = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pvld || pdrop || xo !== 8'd2 || empty) bad++;
    end
    chk("gate_frozen", bad, 0);
    chk("gate_index_hold", pidx, 1);
    vld = 1'b0; ls = 1'b0; ws = 1'b0; tclk = 1'b1;
    tick();
    chk("gate_resume_index", pidx, 2);
    chk("gate_resume_x", xo, 3);

    // background disabled: index 0 mapped through BGP=1B gives shade 3
    bge = 1'b0; bgp = 8'h1B;
    line_start(8'h00);
    push(16'hE4E4);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("bgoff_index", pidx, 0);
      chk("bgoff_color", pcol, 3);
    end
    bge = 1'b1; bgp = 8'hE4;

    // reset mid-line abandons the line without a done pulse
    line_start(8'h00);
    push(16'hE4E4);
    pops(2);
    rst = 1'b1; tclk = 1'b0;
    tick();
    chk("mrst_valid", pvld, 0);
    chk("mrst_x", xo, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_done", ldone, 0);
    rst = 1'b0; tclk = 1'b1;
    push(16'hE4E4);
    chk("mrst_push_ok", empty, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (pvld) bad++;
    end
    chk("mrst_inactive", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
